instr_fetch_unit: RTL and testbench

//  Instruction-fetch stage directly upstream of the opcode decoder in the MIPS datapath.

---
 rtl/instr_fetch_unit.sv | 132 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: holds the fetch PC, issues one outstanding request at a time to
// instruction memory, and buffers returned words in a small FIFO for the decode stage.
// A redirect flushes the FIFO and marks any in-flight response for discard.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned QDEPTH   = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic [31:0] instr_o,
   output logic [5:0]  instr_op_o,
   output logic [31:0] instr_pc_o,
   output logic [31:0] instr_pc4_o
);

   localparam int unsigned PtrW = $clog2(QDEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] DepthC = CntW'(QDEPTH);

   typedef enum logic [1:0] {StRun, StWait, StDrain} state_e;

   state_e          state_q, state_d;
   logic [31:0]     fetch_pc_q, fetch_pc_d;
   logic [31:0]     issue_pc_q, issue_pc_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic [31:0]     data_q [QDEPTH];
   logic [31:0]     data_d [QDEPTH];
   logic [31:0]     fpc_q  [QDEPTH];
   logic [31:0]     fpc_d  [QDEPTH];

   logic        issue, push, pop;
   logic [31:0] redirect_tgt;

   // Request, handshake and FIFO-head outputs
   always_comb begin
      redirect_tgt  = redirect_pc_i & 32'hFFFF_FFFC;
      // Gated by reset so no request is visible while reset is held
      imem_req_o    = rst_i && (state_q == StRun) && (count_q < DepthC);
      imem_addr_o   = fetch_pc_q;
      issue         = imem_req_o && imem_gnt_i;
      instr_valid_o = (count_q != '0);
      pop           = instr_valid_o && instr_ready_i && !redirect_i;
      push          = (state_q == StWait) && imem_rvalid_i && !redirect_i;
      instr_o       = instr_valid_o ? data_q[rd_ptr_q] : 32'h0;
      instr_pc_o    = instr_valid_o ? fpc_q[rd_ptr_q]  : 32'h0;
      instr_op_o    = instr_o[31:26];
      instr_pc4_o   = instr_pc_o + 32'd4;
   end

   // Fetch FSM next state and fetch PC
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      issue_pc_d = issue_pc_q;
      unique case (state_q)
         StRun: begin
            if (issue) begin
               fetch_pc_d = fetch_pc_q + 32'd4;
               issue_pc_d = fetch_pc_q;
               state_d    = StWait;
            end
         end
         StWait:  if (imem_rvalid_i) state_d = StRun;
         StDrain: if (imem_rvalid_i) state_d = StRun;
         default: state_d = StRun;
      endcase
      // A redirect turns any still-pending response into one to discard
      if (redirect_i) begin
         fetch_pc_d = redirect_tgt;
         if (state_d == StWait) state_d = StDrain;
      end
   end

   // FIFO pointer, count and storage next state
   always_comb begin
      data_d   = data_q;
      fpc_d    = fpc_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (redirect_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            data_d[wr_ptr_q] = imem_rdata_i;
            fpc_d[wr_ptr_q]  = issue_pc_q;
            wr_ptr_d         = wr_ptr_q + PtrW'(1);
         end
         if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
         count_d = count_q + CntW'(push) - CntW'(pop);
      end
   end

   // Control state registers
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= StRun;
         fetch_pc_q <= RESET_PC & 32'hFFFF_FFFC;
         issue_pc_q <= 32'h0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         issue_pc_q <= issue_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // FIFO storage; contents are don't-care while count says empty, so no reset
   always_ff @(posedge clk_i) begin
      data_q <= data_d;
      fpc_q  <= fpc_d;
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a memory model answers each issue, and a
// scoreboard of expected PCs is compared against every word the decode side consumes.
module tb_instr_fetch_unit;

   localparam int unsigned Q = 4;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i = 1'b0;
   logic        imem_rvalid_i = 1'b0;
   logic [31:0] imem_rdata_i = 32'h0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = 32'h0;
   logic        instr_valid_o;
   logic        instr_ready_i = 1'b0;
   logic [31:0] instr_o;
   logic [5:0]  instr_op_o;
   logic [31:0] instr_pc_o;
   logic [31:0] instr_pc4_o;

   instr_fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .QDEPTH   (Q)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .instr_valid_o (instr_valid_o),
      .instr_ready_i (instr_ready_i),
      .instr_o       (instr_o),
      .instr_op_o    (instr_op_o),
      .instr_pc_o    (instr_pc_o),
      .instr_pc4_o   (instr_pc4_o)
   );

   always #5 clk_i = ~clk_i;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          issue_cnt = 0;
   int          mem_lat  = 1;
   logic        pend_valid = 1'b0;
   logic [31:0] pend_addr  = 32'h0;
   int          pend_delay = 0;
   logic [31:0] exp_q [$];
   logic [31:0] e_pc, e_word;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[7:2] ^ 6'h2B, a[27:2] ^ 26'h155_5555};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Observe issues and pops mid-cycle, away from the active edge
   always @(negedge clk_i) begin
      if (rst_i && imem_req_o && imem_gnt_i) begin
         issue_cnt++;
         pend_valid = 1'b1;
         pend_addr  = imem_addr_o;
         pend_delay = mem_lat;
      end
      if (rst_i && instr_valid_o && instr_ready_i && !redirect_i) begin
         check("pop_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e_pc   = exp_q.pop_front();
            e_word = mem_word(e_pc);
            check("pop_pc",  instr_pc_o, e_pc);
            check("pop_ins", instr_o, e_word);
            check("pop_op",  32'(instr_op_o), 32'(e_word[31:26]));
            check("pop_pc4", instr_pc4_o, e_pc + 32'd4);
         end
      end
   end

   // Memory model: one response mem_lat cycles after each issue
   always @(posedge clk_i) begin
      #1;
      imem_rvalid_i = 1'b0;
      if (pend_valid) begin
         if (pend_delay <= 1) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(pend_addr);
            pend_valid    = 1'b0;
         end else begin
            pend_delay--;
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_i      = 1'b0;
      redirect_i = 1'b0;
      pend_valid = 1'b0;
      exp_q.delete();
      cyc(2);
      check("rst_req",   32'(imem_req_o),    32'd0);
      check("rst_valid", 32'(instr_valid_o), 32'd0);
      check("rst_instr", instr_o,            32'd0);
      check("rst_pc",    instr_pc_o,         32'd0);
      issue_cnt = 0;
   endtask

   task automatic wait_empty(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (exp_q.size() == 0) break;
         cyc(1);
      end
      check(tag, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic wait_issue(input string tag, input int target, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (issue_cnt >= target) break;
         cyc(1);
      end
      check(tag, 32'(issue_cnt >= target), 32'd1);
   endtask

   initial begin
      #2;
      // 1: streaming fetch from reset
      do_reset();
      imem_gnt_i = 1'b1; instr_ready_i = 1'b1; mem_lat = 1;
      exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
      rst_i = 1'b1;
      wait_empty("t1_drain", 40);
      instr_ready_i = 1'b0;

      // 2: back-pressure fills the FIFO, then drains in order
      do_reset();
      imem_gnt_i = 1'b1; instr_ready_i = 1'b0; mem_lat = 1;
      rst_i = 1'b1;
      cyc(10);
      check("t2_issues", 32'(issue_cnt),     32'(Q));
      check("t2_req",    32'(imem_req_o),    32'd0);
      check("t2_valid",  32'(instr_valid_o), 32'd1);
      for (int i = 0; i < int'(Q) + 2; i++) exp_q.push_back(32'(4 * i));
      instr_ready_i = 1'b1;
      wait_empty("t2_drain", 60);
      instr_ready_i = 1'b0;

      // 3: redirect while waiting drops the in-flight word
      do_reset();
      imem_gnt_i = 1'b1; instr_ready_i = 1'b0; mem_lat = 3;
      rst_i = 1'b1;
      wait_issue("t3_issue", 1, 10);
      redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
      cyc(1);
      redirect_i = 1'b0;
      check("t3_flush", 32'(instr_valid_o), 32'd0);
      for (int i = 0; i < 10; i++) begin
         if (imem_req_o) break;
         cyc(1);
      end
      mem_lat = 1;
      check("t3_req",   32'(imem_req_o),    32'd1);
      check("t3_addr",  imem_addr_o,        32'h0000_0100);
      check("t3_empty", 32'(instr_valid_o), 32'd0);
      exp_q.push_back(32'h0000_0100);
      instr_ready_i = 1'b1;
      wait_empty("t3_drain", 20);
      instr_ready_i = 1'b0;

      // 4: redirect coincident with rvalid and pop, two entries buffered
      do_reset();
      imem_gnt_i = 1'b1; instr_ready_i = 1'b0; mem_lat = 1;
      rst_i = 1'b1;
      wait_issue("t4_issue", 3, 20);
      check("t4_head", instr_pc_o, 32'h0);
      redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200; instr_ready_i = 1'b1;
      cyc(1);
      redirect_i = 1'b0;
      check("t4_empty", 32'(instr_valid_o), 32'd0);
      check("t4_req",   32'(imem_req_o),    32'd1);
      check("t4_addr",  imem_addr_o,        32'h0000_0200);
      exp_q.push_back(32'h0000_0200); exp_q.push_back(32'h0000_0204);
      wait_empty("t4_drain", 30);
      instr_ready_i = 1'b0;

      // 5: grant stall keeps request stable, redirect retargets it
      do_reset();
      imem_gnt_i = 1'b0; instr_ready_i = 1'b0; mem_lat = 1;
      rst_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         check("t5_req",  32'(imem_req_o), 32'd1);
         check("t5_addr", imem_addr_o,     32'h0);
      end
      redirect_i = 1'b1; redirect_pc_i = 32'h0000_0300;
      cyc(1);
      redirect_i = 1'b0;
      check("t5_rreq",  32'(imem_req_o), 32'd1);
      check("t5_raddr", imem_addr_o,     32'h0000_0300);
      imem_gnt_i = 1'b1; instr_ready_i = 1'b1;
      exp_q.push_back(32'h0000_0300);
      wait_empty("t5_drain", 20);
      instr_ready_i = 1'b0;

      // 6: PC wrap, then asynchronous reset in the middle of a wait
      do_reset();
      imem_gnt_i = 1'b1; instr_ready_i = 1'b1; mem_lat = 1;
      rst_i = 1'b1;
      redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
      cyc(1);
      redirect_i = 1'b0;
      exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0); exp_q.push_back(32'h4);
      wait_empty("t6_wrap", 30);
      instr_ready_i = 1'b0;
      mem_lat = 3;
      wait_issue("t6_issue", issue_cnt + 1, 10);
      #2;
      rst_i = 1'b0; imem_gnt_i = 1'b0;
      #1;
      check("t6_rst_req",   32'(imem_req_o),    32'd0);
      check("t6_rst_valid", 32'(instr_valid_o), 32'd0);
      check("t6_rst_instr", instr_o,            32'd0);
      check("t6_rst_pc",    instr_pc_o,         32'd0);
      cyc(1);
      rst_i = 1'b1;
      cyc(4);
      check("t6_late_valid", 32'(instr_valid_o), 32'd0);
      check("t6_late_req",   32'(imem_req_o),    32'd1);
      check("t6_late_addr",  imem_addr_o,        32'h0);
      mem_lat = 1; imem_gnt_i = 1'b1; instr_ready_i = 1'b1;
      exp_q.push_back(32'h0); exp_q.push_back(32'h4);
      wait_empty("t6_drain", 30);
      instr_ready_i = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
